arb_rr_nch: RTL and testbench

- Parametrised successor to the 3-channel buffered arbiter.
- N input channels, each with its own FIFO, merge onto one output port D that uses a valid/grant handshake.
- Round-robin arbitration, or fixed-priority arbitration when selected at runtime.
- New over the previous generation: runtime mode select, a channel-ID output, per-channel drop counters, and a registered output stage.
- Sits between N producer interfaces and a single downstream consumer.

---
 rtl/arb_rr_nch_if.sv | 29 ++
 rtl/arb_rr_nch.sv | 127 ++++++++++++
 tb/tb_arb_rr_nch.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/arb_rr_nch_if.sv
// Bundle between N producers, the arbiter and the single downstream consumer.
// The master modport drives the producer/consumer side; the slave modport is the arbiter.
interface arb_rr_nch_if #(
   parameter int NUM_CH = 3,
   parameter int WIDTH  = 8,
   parameter int CNT_W  = 8,
   parameter int ID_W   = $clog2(NUM_CH)
);
   logic [NUM_CH-1:0]       i_DataValid;
   logic [NUM_CH*WIDTH-1:0] i_DataIn;
   logic [NUM_CH-1:0]       o_DataGrant;
   logic                    i_PrioMode;
   logic                    i_DataGrant_D;
   logic                    o_DataValid_D;
   logic [WIDTH-1:0]        o_DataOut_D;
   logic [ID_W-1:0]         o_ChanId_D;
   logic                    i_DropClr;
   logic [NUM_CH*CNT_W-1:0] o_DropCnt;

   modport master (
      output i_DataValid, i_DataIn, i_PrioMode, i_DataGrant_D, i_DropClr,
      input  o_DataGrant, o_DataValid_D, o_DataOut_D, o_ChanId_D, o_DropCnt
   );

   modport slave (
      input  i_DataValid, i_DataIn, i_PrioMode, i_DataGrant_D, i_DropClr,
      output o_DataGrant, o_DataValid_D, o_DataOut_D, o_ChanId_D, o_DropCnt
   );
endinterface

// File: rtl/arb_rr_nch.sv
// N-channel buffered arbiter: per-channel show-ahead FIFOs merged onto one registered
// valid/grant output, round-robin or fixed-priority, with saturating per-channel drop counters.
module arb_rr_nch #(
   parameter int NUM_CH     = 3,
   parameter int WIDTH      = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8,
   parameter int ID_W       = $clog2(NUM_CH)
) (
   input logic         CLK,
   input logic         SynReset,
   arb_rr_nch_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0]  fifoMem_r [NUM_CH][FIFO_DEPTH];
   logic [AW:0]       wrPtr_r   [NUM_CH];
   logic [AW:0]       rdPtr_r   [NUM_CH];
   logic [CNT_W-1:0]  dropCnt_r [NUM_CH];
   logic [NUM_CH-1:0] full_s, empty_s, push_s, pop_s, drop_s;
   logic [ID_W-1:0]   rrPtr_r, winner_s, cand_s;
   logic [ID_W:0]     sum_s;
   logic              anyReady_s, loadEn_s;
   logic              validD_r;
   logic [WIDTH-1:0]  dataD_r, head_s;
   logic [ID_W-1:0]   chanIdD_r;

   // FIFO status and write-side decode, all from registered pointers
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         empty_s[k] = (wrPtr_r[k] == rdPtr_r[k]);
         full_s[k]  = (wrPtr_r[k][AW] != rdPtr_r[k][AW]) &&
                      (wrPtr_r[k][AW-1:0] == rdPtr_r[k][AW-1:0]);
         push_s[k]  = bus.i_DataValid[k] & ~full_s[k];
         drop_s[k]  = bus.i_DataValid[k] & full_s[k];
      end
   end

   // Winner search: walk candidates from lowest to highest priority so the last hit wins
   always_comb begin
      winner_s   = {ID_W{1'b0}};
      anyReady_s = 1'b0;
      sum_s      = {(ID_W+1){1'b0}};
      cand_s     = {ID_W{1'b0}};
      for (int off = NUM_CH - 1; off >= 0; off--) begin
         sum_s = {1'b0, rrPtr_r} + (ID_W+1)'(off);
         if (bus.i_PrioMode) begin
            cand_s = ID_W'(off);
         end else if (sum_s >= (ID_W+1)'(NUM_CH)) begin
            cand_s = ID_W'(sum_s - (ID_W+1)'(NUM_CH));
         end else begin
            cand_s = sum_s[ID_W-1:0];
         end
         winner_s   = empty_s[cand_s] ? winner_s : cand_s;
         anyReady_s = anyReady_s | ~empty_s[cand_s];
      end
   end

   assign loadEn_s = ~validD_r | bus.i_DataGrant_D;
   assign head_s   = fifoMem_r[winner_s][rdPtr_r[winner_s][AW-1:0]];

   // Pop strobes: only the winner, only when the output register can load
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         pop_s[k] = loadEn_s & anyReady_s & (winner_s == ID_W'(k));
      end
   end

   // FIFO storage and pointers; full is judged before the pop, so a pop never frees a slot same-cycle
   always_ff @(posedge CLK) begin
      for (int k = 0; k < NUM_CH; k++) begin
         if (SynReset) begin
            wrPtr_r[k] <= {(AW+1){1'b0}};
            rdPtr_r[k] <= {(AW+1){1'b0}};
         end else begin
            if (push_s[k]) begin
               fifoMem_r[k][wrPtr_r[k][AW-1:0]] <= bus.i_DataIn[k*WIDTH +: WIDTH];
               wrPtr_r[k] <= wrPtr_r[k] + (AW+1)'(1);
            end
            if (pop_s[k]) begin
               rdPtr_r[k] <= rdPtr_r[k] + (AW+1)'(1);
            end
         end
      end
   end

   // Output register and round-robin pointer
   always_ff @(posedge CLK) begin
      if (SynReset) begin
         validD_r  <= 1'b0;
         dataD_r   <= {WIDTH{1'b0}};
         chanIdD_r <= {ID_W{1'b0}};
         rrPtr_r   <= {ID_W{1'b0}};
      end else if (loadEn_s) begin
         if (anyReady_s) begin
            validD_r  <= 1'b1;
            dataD_r   <= head_s;
            chanIdD_r <= winner_s;
            rrPtr_r   <= (winner_s == ID_W'(NUM_CH - 1)) ? {ID_W{1'b0}} : winner_s + ID_W'(1);
         end else begin
            validD_r <= 1'b0;
         end
      end
   end

   // Saturating drop counters; clear beats a same-cycle increment
   always_ff @(posedge CLK) begin
      for (int k = 0; k < NUM_CH; k++) begin
         if (SynReset || bus.i_DropClr) begin
            dropCnt_r[k] <= {CNT_W{1'b0}};
         end else if (drop_s[k] && (dropCnt_r[k] != CNT_MAX)) begin
            dropCnt_r[k] <= dropCnt_r[k] + CNT_W'(1);
         end
      end
   end

   assign bus.o_DataGrant   = ~full_s;
   assign bus.o_DataValid_D = validD_r;
   assign bus.o_DataOut_D   = dataD_r;
   assign bus.o_ChanId_D    = chanIdD_r;

   genvar g;
   for (g = 0; g < NUM_CH; g++) begin : gDropOut
      assign bus.o_DropCnt[g*CNT_W +: CNT_W] = dropCnt_r[g];
   end
endmodule

// File: tb/tb_arb_rr_nch.sv
// Randomised and directed bench for arb_rr_nch: a queue-based reference model predicts every
// presented word, and a decoupled monitor pops those predictions on each completed transfer.
module tb_arb_rr_nch;
   localparam int N = 3, W = 8, D = 8, CW = 3, IDW = 2;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct { int id; int data; } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   arb_rr_nch_if #(.NUM_CH(N), .WIDTH(W), .CNT_W(CW), .ID_W(IDW)) bus();
   arb_rr_nch #(.NUM_CH(N), .WIDTH(W), .FIFO_DEPTH(D), .CNT_W(CW), .ID_W(IDW))
      dut (.CLK(clk), .SynReset(rst), .bus(bus));

   int   q [N][$];
   bit   mValid;
   int   mData, mId, mPtr;
   int   mDrop [N];
   exp_t expq [$];
   int   seen [$];
   int   total = 0;
   int   bad = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < N; k++) begin
         q[k].delete();
         mDrop[k] = 0;
      end
      mValid = 1'b0; mData = 0; mId = 0; mPtr = 0;
      expq.delete();
   endtask

   // Advance the model over one clock edge with the inputs just applied
   task automatic modelStep(input logic [N-1:0] v, input logic [N*W-1:0] din,
                            input bit g, input bit mode, input bit clr);
      bit acc [N];
      int win;
      for (int k = 0; k < N; k++) acc[k] = v[k] && (q[k].size() < D);
      if (!mValid || g) begin
         win = -1;
         for (int j = 0; j < N; j++) begin
            int c;
            c = mode ? j : (mPtr + j) % N;
            if (win < 0 && q[c].size() > 0) win = c;
         end
         if (win >= 0) begin
            exp_t e;
            mData = q[win].pop_front();
            mId = win;
            mValid = 1'b1;
            mPtr = (win + 1) % N;
            e.id = mId; e.data = mData;
            expq.push_back(e);
         end else begin
            mValid = 1'b0;
         end
      end
      for (int k = 0; k < N; k++) begin
         if (acc[k]) q[k].push_back(int'(din[k*W +: W]));
         if (clr) mDrop[k] = 0;
         else if (v[k] && !acc[k] && mDrop[k] < CMAX) mDrop[k]++;
      end
   endtask

   task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] din, input bit g,
                      input bit mode, input bit clr, input bit r);
      @(posedge clk); #1;
      check("valid", int'(bus.o_DataValid_D), int'(mValid));
      check("dout", int'(bus.o_DataOut_D), mData);
      check("chanid", int'(bus.o_ChanId_D), mId);
      for (int k = 0; k < N; k++) begin
         check("grant", int'(bus.o_DataGrant[k]), int'(q[k].size() < D));
         check("dropcnt", int'(bus.o_DropCnt[k*CW +: CW]), mDrop[k]);
      end
      bus.i_DataValid = v;
      bus.i_DataIn = din;
      bus.i_DataGrant_D = g;
      bus.i_PrioMode = mode;
      bus.i_DropClr = clr;
      rst = r;
      if (r) modelReset();
      else modelStep(v, din, g, mode, clr);
   endtask

   function automatic logic [N*W-1:0] pack3(input int a, input int b, input int c);
      return {W'(c), W'(b), W'(a)};
   endfunction

   task automatic checkSeq(input string name, input int count);
      check({name, "_len"}, seen.size(), count);
      for (int i = 0; i < count && i < seen.size(); i++) check(name, seen[i], i);
      seen.delete();
   endtask

   // Monitor: every completed transfer must match the oldest prediction
   always @(negedge clk) begin
      if (!rst && bus.o_DataValid_D && bus.i_DataGrant_D) begin
         seen.push_back(int'(bus.o_DataOut_D));
         if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_word actual=%0d expected=none", bus.o_DataOut_D);
         end else begin
            exp_t e;
            e = expq.pop_front();
            check("sb_data", int'(bus.o_DataOut_D), e.data);
            check("sb_id", int'(bus.o_ChanId_D), e.id);
         end
      end
   end

   initial begin
      bus.i_DataValid = '0; bus.i_DataIn = '0; bus.i_DataGrant_D = 1'b0;
      bus.i_PrioMode = 1'b0; bus.i_DropClr = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      modelReset();

      // All channels, grant high: strict 0..11 interleave
      cyc('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      seen.delete();
      for (int i = 0; i < 4; i++) cyc(3'b111, pack3(3*i, 3*i+1, 3*i+2), 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (12) cyc('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkSeq("seq_grant_hi", 12);

      // Same data with backpressure, then release
      for (int i = 0; i < 4; i++) cyc(3'b111, pack3(3*i, 3*i+1, 3*i+2), 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (16) cyc('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkSeq("seq_backpress", 12);

      // Overflow all channels under backpressure, then drain and clear counters
      for (int i = 8; i < 20; i++) cyc(3'b111, pack3(3*i, 3*i+1, 3*i+2), 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) cyc('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (30) cyc('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc('0, '0, 1'b1, 1'b0, 1'b1, 1'b0);

      // Fixed priority with preloaded FIFOs, switching back to round-robin mid-drain
      cyc(3'b111, pack3(100, 110, 120), 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(3'b111, pack3(101, 111, 121), 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(3'b111, pack3(102, 112, 122), 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) cyc('0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (8) cyc('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Drop-counter saturation on channel 1, then clear colliding with a drop
      for (int i = 0; i < 20; i++) cyc(3'b010, pack3(0, 200 + i, 0), 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(3'b010, pack3(0, 250, 0), 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(3'b010, pack3(0, 251, 0), 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (14) cyc('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Reset with buffered data and a valid output word; nothing may emerge afterwards
      for (int i = 0; i < 5; i++) cyc(3'b111, pack3(30 + i, 40 + i, 50 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      cyc('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      seen.delete();
      repeat (12) cyc('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("post_reset_words", seen.size(), 0);

      // Randomised traffic with occasional mode flips, clears and resets
      begin
         bit mode;
         mode = 1'b0;
         for (int i = 0; i < 2000; i++) begin
            bit g, r, c;
            if ($urandom_range(15) == 0) mode = ~mode;
            g = (i % 400 < 150) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            c = ($urandom_range(63) == 0);
            r = ($urandom_range(499) == 0);
            cyc(N'($urandom), (N*W)'($urandom), r ? 1'b0 : g, mode, c, r);
         end
      end

      repeat (40) cyc('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("drain_empty", expq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
